// File: rtl/cl_mcl_pkg.sv
// cl_mcl_pkg: host register offsets and transmit-credit constants for the manycore link
package cl_mcl_pkg;

   localparam int mcl_ofs_isr_gp     = 'h00;
   localparam int mcl_ofs_tdfv_gp    = 'h0C;
   localparam int mcl_ofs_tdr_gp     = 'h10;
   localparam int mcl_ofs_rdfo_gp    = 'h1C;
   localparam int mcl_ofs_rdr_gp     = 'h20;
   localparam int mcl_ofs_credits_gp = 'h24;

   localparam int max_out_credits_gp = 16;

   function automatic int credits_width(input int max_credits);
      return $clog2(max_credits + 1);
   endfunction

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin: one-hot round-robin pick starting after the last winner
module bsg_arb_round_robin
   import cl_mcl_pkg::*;
#(
   parameter int width_p = 2,
   localparam int lg_lp = id_width(width_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] reqs_i,
   output logic [width_p-1:0] grants_o,
   output logic [lg_lp-1:0]   sel_id_o,
   input  logic               yumi_i
);

   localparam logic [lg_lp-1:0] last_rst_lp = lg_lp'(width_p - 1);

   logic [lg_lp-1:0] last_r;

   // scan farthest-first so the requester nearest after last_r is written last and wins
   always_comb begin
      int idx;
      idx = 0;
      grants_o = '0;
      sel_id_o = '0;
      for (int i = width_p; i >= 1; i--) begin
         idx = int'(last_r) + i;
         if (idx >= width_p) idx = idx - width_p;
         if (reqs_i[idx]) begin
            grants_o = '0;
            grants_o[idx] = 1'b1;
            sel_id_o = lg_lp'(idx);
         end
      end
   end

   // advance the pointer only when the selected requester is actually taken
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) last_r <= last_rst_lp;
      else if (yumi_i) last_r <= sel_id_o;
   end

endmodule

// File: rtl/fifo_pair_tx_arbiter.sv
// fifo_pair_tx_arbiter: credit-gated round-robin merge of host tx FIFOs onto one link endpoint
module fifo_pair_tx_arbiter
   import cl_mcl_pkg::*;
#(
   parameter int num_req_p = 2,
   parameter int width_p = 128,
   parameter int max_out_credits_p = max_out_credits_gp,
   localparam int credits_width_lp = credits_width(max_out_credits_p),
   localparam int id_width_lp = id_width(num_req_p)
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [num_req_p-1:0]                v_i,
   input  logic [num_req_p-1:0][width_p-1:0]   data_i,
   output logic [num_req_p-1:0]                ready_o,
   output logic                                v_o,
   output logic [width_p-1:0]                  data_o,
   input  logic                                ready_i,
   output logic [id_width_lp-1:0]              grant_id_o,
   input  logic                                credit_return_i,
   output logic [credits_width_lp-1:0]         credits_o,
   output logic                                idle_o,
   output logic                                credit_err_o
);

   localparam logic [credits_width_lp-1:0] max_lp = credits_width_lp'(max_out_credits_p);

   logic                        can_load;
   logic                        load;
   logic                        at_max;
   logic                        v_n;
   logic [credits_width_lp-1:0] credits_n;
   logic [num_req_p-1:0]        grants;
   logic [id_width_lp-1:0]      sel_id;

   // reset gates acceptance so no requester sees ready while reset is held
   assign can_load = ~reset_i & (~v_o | ready_i) & (credits_o != '0);
   assign ready_o = can_load ? grants : '0;
   assign load = |ready_o;
   assign at_max = credits_o == max_lp;

   bsg_arb_round_robin #(.width_p(num_req_p)) rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (v_i),
      .grants_o (grants),
      .sel_id_o (sel_id),
      .yumi_i   (can_load & (|v_i))
   );

   // next valid and credit count; a return at max is dropped rather than wrapping
   always_comb begin
      v_n = load | (v_o & ~ready_i);
      credits_n = credits_o + credits_width_lp'(credit_return_i & ~at_max) - credits_width_lp'(load);
   end

   // output beat register, credit counter, idle flag and sticky overflow error
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_o <= 1'b0;
         data_o <= '0;
         grant_id_o <= '0;
         credits_o <= max_lp;
         idle_o <= 1'b1;
         credit_err_o <= 1'b0;
      end else begin
         v_o <= v_n;
         if (load) begin
            data_o <= data_i[sel_id];
            grant_id_o <= sel_id;
         end
         credits_o <= credits_n;
         idle_o <= ~v_n & (credits_n == max_lp);
         if (credit_return_i & at_max) credit_err_o <= 1'b1;
      end
   end

endmodule
